a2d_analog_model: RTL and testbench

Behavioural/synthesizable model of the 8-channel, 12-bit SPI A2D converter (ADC128S-style) that sits between the eBike's A2D interface and the analog stimulus. It is an SPI slave: each 16-bit transaction shifts in a channel command and shifts out the conversion result of the channel addressed by the previous transaction. Channel inputs are driven directly by the testbench (BATT, BRAKE, TORQUE) and by the physics model (CURR).

---
 rtl/a2d_analog_model_if.sv | 9 +
 rtl/a2d_analog_model.sv | 70 +++++++
 tb/tb_a2d_analog_model.sv | 115 +++++++++++
 3 files changed

// File: rtl/a2d_analog_model_if.sv
// a2d_analog_model_if: SPI bus between the A2D master and the analog model slave.
interface a2d_analog_model_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;
    modport master(output SS_n, SCLK, MOSI, input MISO);
    modport slave(input SS_n, SCLK, MOSI, output MISO);
endinterface

// File: rtl/a2d_analog_model.sv
// a2d_analog_model: 8-channel 12-bit SPI A2D slave model; each frame returns the channel
// addressed by the previous frame.
module a2d_analog_model (
    input  logic                      clk,
    input  logic                      rst,
    a2d_analog_model_if.slave         spi,
    input  logic [11:0]               BATT,
    input  logic [11:0]               CURR,
    input  logic [11:0]               BRAKE,
    input  logic [11:0]               TORQUE
);
    logic [2:0]  ss_q, sclk_q;
    logic [1:0]  mosi_q;
    logic [2:0]  ch_ptr;
    logic [15:0] tx_shft;
    logic [13:0] rx_shft;
    logic [4:0]  bit_cnt;
    logic        rise_seen;
    logic [11:0] ch_val;
    logic        ss_fall, ss_rise, sclk_rise, sclk_fall;

    assign ss_fall   = ss_q[2] & ~ss_q[1];
    assign ss_rise   = ~ss_q[2] & ss_q[1];
    assign sclk_rise = ~sclk_q[2] & sclk_q[1];
    assign sclk_fall = sclk_q[2] & ~sclk_q[1];
    // ss_q[2] flips on the same edge the frame loads, so MISO never shows stale data
    assign spi.MISO  = ~ss_q[2] & tx_shft[15];

    always_comb begin
        ch_val = ch_ptr == 3'd0 ? BATT :
                 ch_ptr == 3'd1 ? CURR :
                 ch_ptr == 3'd3 ? BRAKE :
                 ch_ptr == 3'd4 ? TORQUE : 12'h000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_q      <= 3'b111;
            sclk_q    <= 3'b111;
            mosi_q    <= 2'b00;
            ch_ptr    <= 3'd0;
            tx_shft   <= 16'h0000;
            rx_shft   <= 14'h0000;
            bit_cnt   <= 5'd0;
            rise_seen <= 1'b0;
        end else begin
            ss_q   <= {ss_q[1:0], spi.SS_n};
            sclk_q <= {sclk_q[1:0], spi.SCLK};
            mosi_q <= {mosi_q[0], spi.MOSI};
            if (ss_fall) begin
                tx_shft   <= {4'b0000, ch_val};
                rx_shft   <= 14'h0000;
                bit_cnt   <= 5'd0;
                rise_seen <= 1'b0;
            end else if (!ss_q[1]) begin
                if (sclk_rise) begin
                    rx_shft   <= {rx_shft[12:0], mosi_q[1]};
                    rise_seen <= 1'b1;
                    if (bit_cnt != 5'd16)
                        bit_cnt <= bit_cnt + 5'd1;
                end
                // the leading fall only precedes the first sample, so bit 15 stays put
                if (sclk_fall && rise_seen)
                    tx_shft <= {tx_shft[14:0], 1'b0};
            end else if (ss_rise && bit_cnt == 5'd16) begin
                ch_ptr <= rx_shft[13:11];
            end
        end
    end
endmodule

// File: tb/tb_a2d_analog_model.sv
// tb_a2d_analog_model: directed SPI frames against hand-computed A2D responses.
module tb_a2d_analog_model;
    localparam int HALF = 10;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [11:0] BATT = 12'hAC0, CURR = 12'h000, BRAKE = 12'h000, TORQUE = 12'h000;
    logic [15:0] r;
    int errs = 0, checks = 0;

    a2d_analog_model_if bus ();

    a2d_analog_model dut (
        .clk(clk), .rst(rst), .spi(bus.slave),
        .BATT(BATT), .CURR(CURR), .BRAKE(BRAKE), .TORQUE(TORQUE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [15:0] cmd, input int nbits, input logic chg,
                        input logic [11:0] nb, output logic [15:0] resp);
        resp = 16'h0000;
        bus.SS_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bus.SCLK = 1'b0;
            bus.MOSI = cmd[15-i];
            if (chg && i == 4) BATT = nb;
            repeat (HALF) @(negedge clk);
            resp = {resp[14:0], bus.MISO};
            bus.SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        bus.SS_n = 1'b1;
        repeat (3 * HALF) @(negedge clk);
    endtask

    initial begin
        bus.SS_n = 1'b1;
        bus.SCLK = 1'b1;
        bus.MOSI = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_miso", {15'h0, bus.MISO}, 16'h0000);
        check("reset_ch_ptr", {13'h0, dut.ch_ptr}, 16'h0000);

        xfer(16'h0000, 16, 1'b0, 12'h0, r);
        check("first_batt", r, 16'h0AC0);
        check("ch_ptr_stays0", {13'h0, dut.ch_ptr}, 16'h0000);

        TORQUE = 12'h700;
        xfer(16'h2000, 16, 1'b0, 12'h0, r);
        check("cmd_ch4_resp_batt", r, 16'h0AC0);
        check("ch_ptr_4", {13'h0, dut.ch_ptr}, 16'h0004);
        xfer(16'h2000, 16, 1'b0, 12'h0, r);
        check("torque_700", r, 16'h0700);
        TORQUE = 12'h500;
        xfer(16'h2000, 16, 1'b0, 12'h0, r);
        check("torque_500", r, 16'h0500);

        BRAKE = 12'hFFF;
        xfer(16'h1800, 16, 1'b0, 12'h0, r);
        check("cmd_ch3_resp_torque", r, 16'h0500);
        CURR = 12'h123;
        xfer(16'h0800, 16, 1'b0, 12'h0, r);
        check("brake_fff", r, 16'h0FFF);
        xfer(16'h3000, 16, 1'b0, 12'h0, r);
        check("curr_123", r, 16'h0123);
        xfer(16'h0000, 16, 1'b0, 12'h0, r);
        check("ch6_zero", r, 16'h0000);
        check("ch_ptr_back0", {13'h0, dut.ch_ptr}, 16'h0000);

        xfer(16'h2000, 8, 1'b0, 12'h0, r);
        check("abort_partial", r, 16'h000A);
        check("abort_ch_ptr", {13'h0, dut.ch_ptr}, 16'h0000);
        check("idle_miso_low", {15'h0, bus.MISO}, 16'h0000);
        xfer(16'h2000, 16, 1'b0, 12'h0, r);
        check("after_abort_batt", r, 16'h0AC0);
        check("ch_ptr_4_again", {13'h0, dut.ch_ptr}, 16'h0004);

        bus.SS_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.SCLK = 1'b0;
            repeat (HALF) @(negedge clk);
            bus.SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_miso", {15'h0, bus.MISO}, 16'h0000);
        check("midrst_ch_ptr", {13'h0, dut.ch_ptr}, 16'h0000);
        bus.SS_n = 1'b1;
        bus.SCLK = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        xfer(16'h0000, 16, 1'b1, 12'h555, r);
        check("post_rst_batt_held", r, 16'h0AC0);
        xfer(16'h0000, 16, 1'b0, 12'h0, r);
        check("batt_555", r, 16'h0555);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
